// File: rtl/spatial_bundler_hs.sv
// Spatial bundler: binds each channel with its feature projection, counts per-bit votes over a frame,
// and emits the majority hypervector through a valid/ready stage. Optional macro: SPATIAL_TIEBREAK_EN.
module spatial_bundler_hs #(
  parameter int DIM      = 2000,
  parameter int CHANNELS = 217,
  parameter int FEAT_W   = 2
) (
  input  logic                               Clk_CI,
  input  logic                               Reset_RI,
  input  logic                               Clear_SI,
  input  logic                               InValid_SI,
  output logic                               InReady_SO,
  input  logic [DIM-1:0]                     ChannelHV_DI,
  input  logic [DIM-1:0]                     ProjPos_DI,
  input  logic [DIM-1:0]                     ProjNeg_DI,
  input  logic [FEAT_W-1:0]                  Feature_DI,
  output logic                               OutValid_SO,
  input  logic                               OutReady_SI,
  output logic [DIM-1:0]                     HypervectorOut_DO,
  output logic [$clog2(CHANNELS+2)-1:0]      ChannelIdx_DO
);

  localparam int CNT_W = $clog2(CHANNELS+2);
`ifdef SPATIAL_TIEBREAK_EN
  localparam int THRESH = (CHANNELS+1)/2;
`else
  localparam int THRESH = CHANNELS/2;
`endif
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHANNELS-1);

  typedef enum logic {ACCUM, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] chan_cnt;
  logic [CNT_W-1:0] votes_p0 [DIM];
  logic [DIM-1:0]   hv_p1;
  logic             vld_p1;
  logic [DIM-1:0]   bound, extra, hv_nxt;
  logic             accept, last_beat, handshake;

  // Final vote for one bit: stored count plus this beat's vote and the optional tiebreak vote.
  function automatic logic majority(input logic [CNT_W-1:0] votes, input logic b, input logic e);
    logic [CNT_W-1:0] total;
    total = votes + CNT_W'(b) + CNT_W'(e);
    return total > CNT_W'(THRESH);
  endfunction

  always_comb begin
    bound = '0;
    if (Feature_DI == FEAT_W'(1))      bound = ProjPos_DI ^ ChannelHV_DI;
    else if (Feature_DI == FEAT_W'(2)) bound = ProjNeg_DI ^ ChannelHV_DI;
  end

`ifdef SPATIAL_TIEBREAK_EN
  logic [DIM-1:0] ch1_p0;

  always_ff @(posedge Clk_CI) begin
    if (Reset_RI || Clear_SI)                ch1_p0 <= '0;
    else if (accept && chan_cnt == CNT_W'(1)) ch1_p0 <= bound;
  end

  assign extra = ch1_p0 ^ ChannelHV_DI;
`else
  assign extra = '0;
`endif

  always_comb begin
    for (int i = 0; i < DIM; i++) hv_nxt[i] = majority(votes_p0[i], bound[i], extra[i]);
  end

  always_comb begin
    state_nxt  = state;
    InReady_SO = (state == ACCUM);
    accept     = InValid_SI && (state == ACCUM) && !Clear_SI;
    last_beat  = accept && (chan_cnt == LAST_IDX);
    handshake  = vld_p1 && OutReady_SI;
    case (state)
      ACCUM:   if (last_beat) state_nxt = DONE;
      DONE:    if (Clear_SI || handshake) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) state <= ACCUM;
    else          state <= state_nxt;
  end

  always_ff @(posedge Clk_CI) begin
    if (Reset_RI || Clear_SI || last_beat) chan_cnt <= '0;
    else if (accept)                       chan_cnt <= chan_cnt + CNT_W'(1);
  end

  // Stage p0: per-bit vote accumulation; channel 0 overwrites the previous frame.
  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      for (int i = 0; i < DIM; i++) votes_p0[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < DIM; i++)
        votes_p0[i] <= (chan_cnt == '0) ? CNT_W'(bound[i]) : votes_p0[i] + CNT_W'(bound[i]);
    end
  end

  // Stage p1: registered majority output with valid/ready hold.
  always_ff @(posedge Clk_CI) begin
    if (Reset_RI)                                           vld_p1 <= 1'b0;
    else if (last_beat)                                     vld_p1 <= 1'b1;
    else if (state == DONE && (Clear_SI || handshake))      vld_p1 <= 1'b0;
  end

  always_ff @(posedge Clk_CI) begin
    if (Reset_RI)       hv_p1 <= '0;
    else if (last_beat) hv_p1 <= hv_nxt;
  end

  assign OutValid_SO       = vld_p1;
  assign HypervectorOut_DO = hv_p1;
  assign ChannelIdx_DO     = (state == DONE) ? '0 : chan_cnt;

endmodule

// File: doc/spatial_bundler_hs.md
Name: spatial_bundler_hs

Overview:
- Parametrised next-generation spatial encoder/accumulator for the HD sensor-fusion datapath.
- Receives one bound channel per handshake beat. Each beat's channel hypervector is XORed with the projection vector that the channel's quantised feature selects.
- Counts per-bit votes over a fixed number of channels and emits the majority hypervector through a valid/ready output stage.
- Sits between the item-memory/projection lookup and the temporal encoder.
- Adds frame sequencing, backpressure, abort, and a channel count that is set by parameter instead of hard-coded.

Parameters:
- DIM, 2000, hypervector dimension in bits.
- CHANNELS, 217, channels bundled per frame; must be >= 2.
- FEAT_W, 2, width of the quantised feature code.
- CNT_W (localparam), $clog2(CHANNELS+2), per-bit vote counter width.
- THRESH (localparam), CHANNELS/2 (integer division); output bit is 1 iff count > THRESH.

Ports:
- Clk_CI  in  1  clock.
- Reset_RI  in  1  synchronous active-high reset.
- Clear_SI  in  1  abort current frame; discard all votes.
- InValid_SI  in  1  input beat valid.
- InReady_SO  out  1  block can accept an input beat.
- ChannelHV_DI  in  DIM  channel identity hypervector.
- ProjPos_DI  in  DIM  projection vector for feature code 1.
- ProjNeg_DI  in  DIM  projection vector for feature code 2.
- Feature_DI  in  FEAT_W  quantised feature code.
- OutValid_SO  out  1  HypervectorOut_DO holds a completed frame.
- OutReady_SI  in  1  downstream accepts the output.
- HypervectorOut_DO  out  DIM  bundled majority hypervector, registered.
- ChannelIdx_DO  out  CNT_W  index of the next channel to be accepted.

Behaviour:
- Clock and reset:
  - Single clock Clk_CI.
  - Reset_RI is synchronous and active-high, and has priority over every other input.
- Reset values:
  - State = ACCUM.
  - All vote counters = 0; channel counter = 0.
  - OutValid_SO = 0; HypervectorOut_DO = all 0.
  - ChannelIdx_DO = 0; InReady_SO = 1.
- Bound vector per beat: bit i =
  - ProjPos_DI[i] ^ ChannelHV_DI[i] when Feature_DI == 1;
  - ProjNeg_DI[i] ^ ChannelHV_DI[i] when Feature_DI == 2;
  - 0 for codes 0 and 3 (no vote).
- State ACCUM:
  - InReady_SO = 1. A beat is accepted when InValid_SI & InReady_SO.
  - Channel 0 beat: counter[i] loads the bound bit. Prior-frame contents are overwritten, not added to.
  - Channels 1..CHANNELS-1: counter[i] += bound bit.
  - Every accepted beat increments the channel counter.
  - Counters cannot overflow: maximum value is CHANNELS (CHANNELS+1 with the optional feature) and fits in CNT_W.
  - Beat with channel counter == CHANNELS-1:
    - HypervectorOut_DO[i] registers (final count[i] > THRESH). The final count includes that last beat's vote, computed combinationally.
    - OutValid_SO rises on the next edge; state -> DONE; channel counter -> 0.
  - Latency: OutValid_SO is high 1 cycle after the last accepted beat.
- State DONE:
  - InReady_SO = 0.
  - HypervectorOut_DO and OutValid_SO are held stable until OutReady_SI = 1.
  - On OutValid_SO & OutReady_SI: OutValid_SO -> 0 and state -> ACCUM on the next edge. A new beat is accepted no earlier than that next cycle.
  - HypervectorOut_DO retains its last value after the handshake.
- Clear_SI:
  - In ACCUM: channel counter -> 0 and the next beat is treated as channel 0; any beat presented in the same cycle is dropped.
  - In DONE: OutValid_SO -> 0, state -> ACCUM, and the pending output is discarded.
  - Clear_SI has priority over a simultaneous handshake.
- Reset mid-frame or in DONE: full return to reset values; partial votes are lost.
- ChannelIdx_DO equals the channel counter and reads 0 whenever the block is in DONE.

Optional Feature:
- SPATIAL_TIEBREAK_EN defined:
  - The bound vector of channel 1 is latched into a DIM-bit register when that beat is accepted.
  - On the last beat, each bit adds an extra vote equal to (latched ch1 bit ^ ChannelHV_DI bit of the last beat). This vote is added on top of the last beat's normal vote.
  - Total votes = CHANNELS+1; threshold becomes (CHANNELS+1)/2, strict greater-than.
  - The latch resets to 0 and clears on Clear_SI.
- Undefined: no latch register, no extra vote, THRESH = CHANNELS/2.

Test Plan:
- DIM=8, CHANNELS=5, THRESH=2. Send 5 beats with Feature=1, ProjPos=0xFF, ChannelHV=0x00 -> OutValid_SO high 1 cycle after beat 5 with HypervectorOut_DO=0xFF; ChannelIdx_DO counts 0..4, then reads 0 once in DONE.
- Same parameters. 3 beats give bound vector 0x0F and 2 beats give 0xF0 -> output 0x0F (counts 3 vs 2). A second frame with 2 beats of 0x0F and 3 beats of 0xF0 -> output 0xF0, confirming channel 0 overwrites rather than adds.
- Feature=0 or 3 on every beat -> output 0x00. Feature=2 with ProjNeg=0xAA, ChannelHV=0x00 -> output 0xAA.
- Hold OutReady_SI low for 6 cycles in DONE while InValid_SI stays high -> InReady_SO=0, output stable, no beat consumed. On OutReady_SI=1, the next frame starts at ChannelIdx_DO=0.
- Assert Clear_SI after 3 beats, then send 5 beats of 0xFF -> output 0xFF. Assert Reset_RI in DONE -> OutValid_SO=0 and HypervectorOut_DO=0x00 on the next edge.
- SPATIAL_TIEBREAK_EN with DIM=8, CHANNELS=4, threshold 2:
  - Setup: bound ch1=0xFF, ChannelHV of the last beat=0x0F, per-bit votes 2 of 4.
  - Response: bits 7:4 get the extra vote, 3 > 2 -> 1; bits 3:0 do not, 2 -> 0; output=0xF0.
